// File: rtl/poly_fios_pkg.sv
// Shared types and constants for the POLY_FIOS job sequencer.
package poly_fios_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] WR_SEL_B   = 2'd0;
    localparam logic [1:0] WR_SEL_M   = 2'd1;
    localparam logic [1:0] WR_SEL_MP0 = 2'd2;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_buffer.sv
// Word-slice register file: synchronous write, asynchronous read, no reset.
module slice_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 85,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Slice storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/poly_fios_ctrl.sv
// Job-level sequencer for one POLY_FIOS array: operand buffers, start/shift/done
// handling, cycle counting with timeout, and a valid/ready response.
module poly_fios_ctrl
    import poly_fios_pkg::*;
#(
    parameter int WORD_WIDTH = 17,
    parameter int N          = 5,
    parameter int S          = 4,
    parameter int TIMEOUT    = 1024,
    localparam int PTR_W     = width_of(S),
    localparam int CNT_W     = width_of(TIMEOUT + 1),
    localparam int DW        = N * WORD_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_sel_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_err_o,
    output logic [CNT_W-1:0] resp_cycles_o,
    output logic             wr_drop_o,
    output logic             start_o,
    output logic [DW-1:0]    B_din_o,
    output logic [DW-1:0]    M_din_o,
    output logic [DW-1:0]    M_prime_0_din_o,
    input  logic             mem_B_reg_shift_i,
    input  logic             mem_M_reg_shift_i,
    input  logic             done_i,
    output logic             shift_ovf_o
);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(S - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    ctrl_state_t      state_r;
    logic [PTR_W-1:0] b_ptr_r, m_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [DW-1:0]    mp0_r;
    logic             req_ready_r, resp_valid_r, resp_err_r, start_r;
    logic             wr_drop_r, shift_ovf_r;
    logic             b_we_s, m_we_s, mp0_we_s, drop_s;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Route operand writes to their target in IDLE; flag them anywhere else
    always_comb begin
        b_we_s   = 1'b0;
        m_we_s   = 1'b0;
        mp0_we_s = 1'b0;
        drop_s   = 1'b0;
        if (wr_en_i) begin
            if (state_r == ST_IDLE) begin
                case (wr_sel_i)
                    WR_SEL_B:   b_we_s   = 1'b1;
                    WR_SEL_M:   m_we_s   = 1'b1;
                    WR_SEL_MP0: mp0_we_s = 1'b1;
                    default:    b_we_s   = 1'b0;
                endcase
            end else begin
                drop_s = (wr_sel_i != 2'd3);
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Job FSM with pointers, cycle counter and all registered outputs
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_r      <= ST_IDLE;
            b_ptr_r      <= '0;
            m_ptr_r      <= '0;
            cnt_r        <= '0;
            mp0_r        <= '0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            start_r      <= 1'b0;
            wr_drop_r    <= 1'b0;
            shift_ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_r) begin
                        state_r     <= ST_START;
                        req_ready_r <= 1'b0;
                        start_r     <= 1'b1;
                        b_ptr_r     <= '0;
                        m_ptr_r     <= '0;
                        cnt_r       <= '0;
                        resp_err_r  <= 1'b0;
                        wr_drop_r   <= 1'b0;
                        shift_ovf_r <= 1'b0;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_START: begin
                    start_r <= 1'b0;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    cnt_r <= cnt_inc_s;
                    if (mem_B_reg_shift_i) begin
                        if (b_ptr_r == PTR_LAST) shift_ovf_r <= 1'b1;
                        else                     b_ptr_r     <= b_ptr_r + PTR_W'(1);
                    end
                    if (mem_M_reg_shift_i) begin
                        if (m_ptr_r == PTR_LAST) shift_ovf_r <= 1'b1;
                        else                     m_ptr_r     <= m_ptr_r + PTR_W'(1);
                    end
                    // done has priority over a coincident timeout
                    if (done_i) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                    end else if (cnt_inc_s == CNT_LIMIT) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    start_r      <= 1'b0;
                end
            endcase
            if (drop_s)   wr_drop_r <= 1'b1;
            if (mp0_we_s) mp0_r     <= wr_data_i;
        end
    end

    slice_buffer #(.DEPTH(S), .WIDTH(DW), .AW(PTR_W)) u_b_buf (
        .clk     (clock_i),
        .wr_en   (b_we_s),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (b_ptr_r),
        .rd_data (B_din_o)
    );

    slice_buffer #(.DEPTH(S), .WIDTH(DW), .AW(PTR_W)) u_m_buf (
        .clk     (clock_i),
        .wr_en   (m_we_s),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (m_ptr_r),
        .rd_data (M_din_o)
    );

    assign req_ready_o     = req_ready_r;
    assign resp_valid_o    = resp_valid_r;
    assign resp_err_o      = resp_err_r;
    assign resp_cycles_o   = cnt_r;
    assign wr_drop_o       = wr_drop_r;
    assign start_o         = start_r;
    assign M_prime_0_din_o = mp0_r;
    assign shift_ovf_o     = shift_ovf_r;

endmodule

// File: tb/tb_poly_fios_ctrl.sv
// Directed-plus-random bench for poly_fios_ctrl with a job-level reference model.
module tb_poly_fios_ctrl;

    localparam int WW = 17;
    localparam int N  = 5;
    localparam int S  = 4;
    localparam int TO = 1024;
    localparam int DW = N * WW;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_sel = 2'd0;
    logic [1:0]    wr_addr = 2'd0;
    logic [DW-1:0] wr_data = '0;
    logic          req_valid = 1'b0, resp_ready = 1'b0;
    logic          bsh = 1'b0, msh = 1'b0, done = 1'b0;
    logic          req_ready, resp_valid, resp_err, wr_drop, start, shift_ovf;
    logic [10:0]   resp_cycles;
    logic [DW-1:0] b_din, m_din, mp0_din;

    logic [DW-1:0] bm [S];
    logic [DW-1:0] mm [S];
    logic [DW-1:0] mp0m;
    int passed = 0, total = 0;

    poly_fios_ctrl dut (
        .clock_i(clk), .reset_i(reset_i), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .req_valid_i(req_valid),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_err_o(resp_err), .resp_cycles_o(resp_cycles), .wr_drop_o(wr_drop),
        .start_o(start), .B_din_o(b_din), .M_din_o(m_din), .M_prime_0_din_o(mp0_din),
        .mem_B_reg_shift_i(bsh), .mem_M_reg_shift_i(msh), .done_i(done),
        .shift_ovf_o(shift_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rep(input int v);
        logic [WW-1:0] w;
        w = WW'(v);
        return {N{w}};
    endfunction

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic write(input logic [1:0] sel, input int addr, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 2'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic request();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("start_pulse", 128'(start), 128'(1'b1));
        check("b_slice0_at_start", 128'(b_din), 128'(bm[0]));
        check("m_slice0_at_start", 128'(m_din), 128'(mm[0]));
        check("flags_clear_on_accept", 128'({shift_ovf, wr_drop, req_ready}), 128'(3'b000));
        tick();
        check("start_one_cycle", 128'(start), 128'(1'b0));
    endtask

    // Run one job: B shifts on even cycles, M shifts on odd cycles, done at done_at (0 = never)
    task automatic do_run(input int done_at, input int nb, input int nm, input bit drop_wr);
        int  bp = 0, mp = 0, endc = 0;
        bit  ovf = 1'b0, got = 1'b0, ok_done;
        int  exp_end;
        ok_done = (done_at >= 1 && done_at <= TO);
        exp_end = ok_done ? done_at : TO;
        for (int c = 1; c <= TO + 20 && !got; c++) begin
            bsh  = (c % 2 == 0) && (c / 2 <= nb);
            msh  = (c % 2 == 1) && ((c - 1) / 2 < nm);
            done = (c == done_at);
            if (drop_wr && c == 1) begin
                wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 2'd0; wr_data = ~bm[0];
            end
            tick();
            wr_en = 1'b0;
            if (bsh) begin
                if (bp == S - 1) ovf = 1'b1; else bp++;
                check("b_din_after_shift", 128'(b_din), 128'(bm[bp]));
            end
            if (msh) begin
                if (mp == S - 1) ovf = 1'b1; else mp++;
                check("m_din_after_shift", 128'(m_din), 128'(mm[mp]));
            end
            if (drop_wr && c == 1) check("wr_drop_set", 128'(wr_drop), 128'(1'b1));
            if (resp_valid) begin
                got = 1'b1;
                endc = c;
            end
        end
        bsh = 1'b0; msh = 1'b0; done = 1'b0;
        check("resp_seen", 128'(got), 128'(1'b1));
        check("resp_latency", 128'(endc), 128'(exp_end));
        check("resp_cycles", 128'(resp_cycles), 128'(exp_end));
        check("resp_err", 128'(resp_err), 128'(!ok_done));
        check("shift_ovf", 128'(shift_ovf), 128'(ovf));
    endtask

    task automatic finish_resp(input bit keep_valid);
        resp_ready = 1'b1;
        req_valid = keep_valid;
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b0;
        check("resp_released", 128'(resp_valid), 128'(1'b0));
        check("no_accept_in_resp", 128'(start), 128'(1'b0));
        check("ready_after_resp", 128'(req_ready), 128'(1'b1));
    endtask

    initial begin
        logic [10:0] held_cycles;
        logic        held_err;
        int          da;

        // Reset state
        tick(); tick();
        check("rst_outputs", 128'({req_ready, resp_valid, resp_err, wr_drop, start, shift_ovf}), 128'(6'b0));
        check("rst_cycles", 128'(resp_cycles), 128'(0));
        check("rst_mp0", 128'(mp0_din), 128'(0));
        reset_i = 1'b1;
        tick();
        check("ready_after_rst", 128'(req_ready), 128'(1'b1));

        // Load operands: B slices 1..4 per coefficient, random M and M_prime_0
        for (int i = 0; i < S; i++) begin
            bm[i] = rep(i + 1);
            write(2'd0, i, bm[i]);
            mm[i] = rnd();
            write(2'd1, i, mm[i]);
        end
        mp0m = rnd();
        write(2'd2, 0, mp0m);
        write(2'd3, 1, rnd());
        check("mp0_loaded", 128'(mp0_din), 128'(mp0m));
        check("sel3_no_drop", 128'(wr_drop), 128'(1'b0));
        check("b_din_idle", 128'(b_din), 128'(bm[0]));

        // Normal job: three B shifts, done at RUN cycle 90
        request();
        do_run(90, 3, 2, 1'b0);
        finish_resp(1'b0);

        // Timeout with no done
        request();
        do_run(0, 0, 1, 1'b0);
        finish_resp(1'b0);

        // done coincident with timeout
        request();
        do_run(TO, 1, 0, 1'b0);
        finish_resp(1'b0);

        // Over-shift on both pointers, random done point
        for (int i = 0; i < S; i++) begin
            bm[i] = rnd();
            write(2'd0, i, bm[i]);
        end
        request();
        da = 20 + int'($urandom_range(60));
        do_run(da, 5, 4, 1'b0);
        finish_resp(1'b0);

        // Dropped write in RUN, response held for 5 cycles with a pending request
        request();
        da = 30 + int'($urandom_range(40));
        do_run(da, 2, 2, 1'b1);
        held_cycles = resp_cycles;
        held_err = resp_err;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("resp_held_valid", 128'(resp_valid), 128'(1'b1));
            check("resp_held_fields", 128'({held_err, held_cycles}), 128'({resp_err, resp_cycles}));
            check("no_accept_held", 128'({start, req_ready}), 128'(2'b00));
        end
        finish_resp(1'b1);
        request();
        do_run(40, 1, 0, 1'b0);
        finish_resp(1'b0);

        // Reset pulse mid-RUN
        request();
        bsh = 1'b1;
        tick(); tick();
        bsh = 1'b0;
        write(2'd1, 0, rnd());
        check("drop_before_rst", 128'(wr_drop), 128'(1'b1));
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        mp0m = '0;
        check("midrst_outputs", 128'({req_ready, resp_valid, resp_err, wr_drop, start, shift_ovf}), 128'(6'b0));
        check("midrst_cycles", 128'(resp_cycles), 128'(0));
        check("midrst_mp0", 128'(mp0_din), 128'(mp0m));
        tick();
        check("midrst_ready", 128'(req_ready), 128'(1'b1));
        check("midrst_b_preserved", 128'(b_din), 128'(bm[0]));
        check("midrst_m_preserved", 128'(m_din), 128'(mm[0]));
        request();
        do_run(25, 3, 1, 1'b0);
        finish_resp(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/poly_fios_ctrl.md
# poly_fios_ctrl

Job-level sequencer for the POLY_FIOS systolic multiplier array. It holds the S word-slices of operands B and M plus the M_prime_0 vector, and accepts one multiplication request at a time through a valid/ready handshake. For each request it pulses the array start, serves the B/M slices in order on the array's shift requests, and waits for the array's done. It then returns a response carrying the cycle count, or a timeout error. It sits between the host/bus-facing logic and one POLY_FIOS instance; operand A is driven by the host directly.

## Interface
- WORD_WIDTH, 17, DSP word width; matches the array.
- N, 5, coefficients per AMNS polynomial.
- S, 4, word slices per coefficient; depth of the B and M buffers.
- TIMEOUT, 1024, maximum RUN cycles before abort; must exceed S*(4N+2)+4N.
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  reset; synchronous and active-low.
- wr_en_i  in  1  operand write strobe.
- wr_sel_i  in  2  0=B buffer, 1=M buffer, 2=M_prime_0 register, 3=reserved (write ignored).
- wr_addr_i  in  $clog2(S)  slice index for B/M writes.
- wr_data_i  in  N*WORD_WIDTH  slice data, coefficient i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- req_valid_i / req_ready_o  in/out  1  request handshake.
- resp_valid_o / resp_ready_i  out/in  1  response handshake.
- resp_err_o  out  1  1 = timeout abort; qualified by resp_valid_o.
- resp_cycles_o  out  $clog2(TIMEOUT+1)  RUN-state cycle count.
- wr_drop_o  out  1  sticky; a write arrived outside IDLE. Cleared on request acceptance.
- start_o  out  1  one-cycle start pulse to the array.
- B_din_o, M_din_o  out  N*WORD_WIDTH  current B/M slice to the array.
- M_prime_0_din_o  out  N*WORD_WIDTH  M_prime_0 register contents.
- mem_B_reg_shift_i, mem_M_reg_shift_i  in  1  slice-advance requests from the array.
- done_i  in  1  array completion.
- shift_ovf_o  out  1  sticky; a shift request arrived at slice S-1. Cleared on request acceptance.

## Operation
- States: IDLE, START, RUN, RESP.
- IDLE:
  - req_ready_o=1.
  - Writes land in the buffers on the same edge.
  - Accepting a request (req_valid_i && req_ready_o) moves to START, zeroes b_ptr, m_ptr and the cycle counter, and clears the sticky flags.
- START: start_o=1 for exactly one cycle, then RUN.
- RUN:
  - Counter increments each cycle.
  - mem_B_reg_shift_i increments b_ptr and mem_M_reg_shift_i increments m_ptr; the two are independent.
  - A pointer already at S-1 holds and sets shift_ovf_o.
  - done_i moves to RESP with err=0.
  - Counter reaching TIMEOUT moves to RESP with err=1.
  - done_i and timeout in the same cycle: done wins, err=0.
- RESP:
  - resp_valid_o=1; resp_err_o and resp_cycles_o stay stable.
  - resp_ready_i returns to IDLE.
  - A new request is not accepted in the same cycle.
- done_i and shift inputs are ignored outside RUN.
- Writes outside IDLE are dropped and set wr_drop_o; wr_sel_i=3 is silently ignored.
- B_din_o = Bbuf[b_ptr], M_din_o = Mbuf[m_ptr]: combinational reads from registered pointers.
- Reset value of every output is 0, except req_ready_o=1 one cycle after reset deasserts.
- Reset mid-operation: returns to IDLE, clears pointers, counter and flags, and drops any pending response. Buffer contents are not reset. M_prime_0 resets to 0.

## Timing
- Request accepted at edge k → start_o high in cycle k+1 → RUN from k+2.
- done_i sampled high in RUN at edge d → resp_valid_o high from cycle d+1.
- Shift sampled at edge t → new slice on B_din_o/M_din_o in cycle t+1.
- After acceptance, the slice-0 data is visible while start_o is high.
- resp_cycles_o = number of RUN cycles, including the cycle in which done_i was sampled.
- Minimum request-to-request spacing: 4 cycles.

## Structure
- Package poly_fios_pkg holds:
  - state enum ctrl_state_t;
  - wr_sel encodings WR_SEL_B, WR_SEL_M, WR_SEL_MP0;
  - helper width function for counter and pointer sizing.
- One sub-module, slice_buffer: an S×(N*WORD_WIDTH) register file with a synchronous write port and an asynchronous read port, instantiated twice (B, M).
- FSM, pointers and counter live in the top.

## Test plan
- Load B slices 0..3 = 0x1..0x4 per coefficient; request; array model shifts 3 times, done at RUN cycle 90 → B_din_o steps 1,2,3,4; resp_valid, err=0, cycles=90.
- Request with no done → resp at RUN cycle 1024 with err=1, cycles=1024; resp_ready → IDLE, req_ready=1.
- done_i and counter reaching TIMEOUT in the same cycle → err=0.
- Four B shifts → b_ptr stays at 3, shift_ovf_o=1; next request acceptance clears it.
- Write during RUN → buffer unchanged, wr_drop_o=1; resp_ready held low for 5 cycles → resp fields stable, no new accept.
- reset_i low for 1 cycle mid-RUN → next cycle IDLE, all outputs 0 except req_ready_o=1 one cycle later, B buffer data preserved.
